unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory between the fetch stage (IF) and the load/store stage (D).
//  Performs at most one memory access per cycle; a data access wins by default, and a fairness counter bounds IF starvation.
//  Registers read responses, checks data alignment, and adds the data-region base to data addresses.
//  Sits between the pipeline stages and the memory; any requester without a grant stalls.
// PARAMETERS
//  ADDR_W          8    requester byte-address width
//  DATA_BASE       256  byte offset of the data region, added to d_addr
//  MAX_DATA_BURST  2    max consecutive D grants while if_req is pending (must be >=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  if_req     in   1      fetch request; hold it and if_addr stable until if_gnt
//  if_addr    in   ADDR_W fetch byte address (word access)
//  if_gnt     out  1      IF access performed this cycle
//  if_rvalid  out  1      one-cycle pulse; if_rdata valid
//  if_rdata   out  32     registered instruction word
//  d_req      in   1      data request; hold it and the payload until d_gnt
//  d_we       in   1      1=store, 0=load
//  d_func3    in   3      000 b, 001 h, 010 w, 100 bu, 101 hu
//  d_addr     in   ADDR_W data byte address, relative to the data region
//  d_wdata    in   32     store data
//  d_gnt      out  1      D request accepted this cycle
//  d_rvalid   out  1      one-cycle pulse for loads and errors
//  d_rdata    out  32     registered load data (0 on error)
//  d_err      out  1      qualifies d_rvalid; misaligned access
//  mem_addr   out  ADDR_W+1 memory byte address
//  mem_read   out  1      memory read strobe
//  mem_write  out  1      memory write strobe, taken at posedge
//  mem_func3  out  3      size/sign to memory (010 for IF)
//  mem_wdata  out  32     store data to memory
//  mem_rdata  in   32     combinational memory read data
// BEHAVIOUR
//  Reset: every output register is 0, burst_cnt=0, last_owner=IDLE, and all pending responses are dropped.
//  Grant is combinational in the request cycle:
//   - data_pick = d_req & ~(if_req & burst_cnt==MAX_DATA_BURST).
//   - if_gnt = if_req & ~data_pick.
//   - d_gnt = d_req & data_pick.
//  Memory drive:
//   - IF grant: mem_addr=if_addr, mem_read=1, mem_func3=010.
//   - D grant: mem_addr=d_addr+DATA_BASE (no truncation), mem_func3=d_func3, mem_read=~d_we, mem_write=d_we.
//   - No grant, or misaligned D: mem_read, mem_write and mem_wdata are 0.
//  Misaligned access: h/hu with addr[0]=1, or w with addr[1:0]!=0. It is still granted but does not touch memory.
//   - Next cycle: d_rvalid=1, d_err=1, d_rdata=0.
//  Unsupported func3 on a load (011, 110, 111): performed as a read; memory returns 0.
//  Latency: read data is captured at the posedge ending the grant cycle.
//   - if_rvalid or d_rvalid is high in the cycle after grant, for exactly 1 cycle.
//   - Stores produce no rvalid (unless misaligned).
//  burst_cnt (sequential):
//   - D grant with if_req high: +1, saturates at MAX.
//   - IF grant, or if_req low: clears to 0.
//  last_owner register: IDLE, FETCH or DATA, updated every cycle (debug/visibility).
//  Simultaneous requests: D,D,...(MAX times),I repeats. Lone requests are granted every cycle, back to back.
//  rst asserted in a grant cycle: the write, if any, still reaches memory that edge. All rvalids are 0 the next cycle.
// TESTING
//  T1: rst=1 for 2 cycles with both reqs high -> no rvalid after reset, burst_cnt=0, mem_read/mem_write=0 in cycles after reset.
//  T2: IF only, if_addr=8, mem_rdata=32'hFF000213 -> if_gnt and mem_addr=8 the same cycle; next cycle if_rvalid=1, if_rdata=32'hFF000213.
//  T3: both reqs held high, MAX=2 -> grant sequence D,D,I,D,D,I; IF never waits more than 2 cycles.
//  T4: sw (d_we=1, func3=010, d_addr=4, d_wdata=5) -> mem_addr=260, mem_write=1, d_gnt=1; no d_rvalid.
//  T5: lw with d_addr=2 -> d_gnt=1 and mem_read=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
//  T6: lh with d_addr=24, mem_rdata=32'h0000F157 -> next cycle d_rvalid=1, d_rdata=32'h0000F157; rst at the grant edge suppresses d_rvalid.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one unified instruction/data memory between the fetch stage (IF) and the
//   load/store stage (D). At most one access per cycle; D wins by default, and a burst
//   counter forces an IF grant after MAX_DATA_BURST consecutive D grants while IF waits.
//   Read responses are registered (valid the cycle after the grant). Data addresses are
//   offset by DATA_BASE, and misaligned data accesses are granted without touching memory
//   and answered with an error response.
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_req/i_if_addr        fetch request (held until o_if_gnt)
//   o_if_gnt                  fetch access performed this cycle
//   o_if_rvalid/o_if_rdata    registered fetch response (1-cycle pulse)
//   i_d_req/i_d_we/i_d_func3/i_d_addr/i_d_wdata  data request (held until o_d_gnt)
//   o_d_gnt                   data request accepted this cycle
//   o_d_rvalid/o_d_rdata/o_d_err  registered load / error response (1-cycle pulse)
//   o_mem_*/i_mem_rdata       memory interface, i_mem_rdata is combinational
//   o_last_owner              debug: owner of the previous cycle (0 idle, 1 fetch, 2 data)
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_BASE      = 256,
  parameter int unsigned MAX_DATA_BURST = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [31:0]       o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [2:0]        i_d_func3,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic              o_d_gnt,
  output logic              o_d_rvalid,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_err,
  output logic [ADDR_W:0]   o_mem_addr,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [2:0]        o_mem_func3,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic [1:0]        o_last_owner
);

  localparam int unsigned     CNT_W      = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);
  localparam logic [ADDR_W:0] BASE_OFS   = (ADDR_W + 1)'(DATA_BASE);

  typedef enum logic [1:0] {OwnIdle = 2'd0, OwnFetch = 2'd1, OwnData = 2'd2} owner_e;

  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_d;
  owner_e           r_last_owner, w_last_owner_d;

  logic w_burst_full, w_data_pick, w_if_gnt, w_d_gnt, w_misaligned, w_d_access, w_d_resp;

  // Grant decision
  always_comb begin
    w_burst_full = (r_burst_cnt == BURST_MAX);
    w_data_pick  = i_d_req & ~(i_if_req & w_burst_full);
    w_if_gnt     = i_if_req & ~w_data_pick;
    w_d_gnt      = i_d_req & w_data_pick;
  end

  always_comb begin
    w_misaligned = 1'b0;
    case (i_d_func3)
      3'b001, 3'b101: w_misaligned = i_d_addr[0];
      3'b010:         w_misaligned = |i_d_addr[1:0];
      default:        w_misaligned = 1'b0;
    endcase
    w_d_access = w_d_gnt & ~w_misaligned;
    // Loads and error responses produce d_rvalid; good stores do not
    w_d_resp   = w_d_gnt & (~i_d_we | w_misaligned);
  end

  // Memory drive
  always_comb begin
    o_mem_addr  = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_func3 = 3'b000;
    o_mem_wdata = 32'h0;
    if (w_if_gnt) begin
      o_mem_addr  = {1'b0, i_if_addr};
      o_mem_read  = 1'b1;
      o_mem_func3 = 3'b010;
    end else if (w_d_gnt) begin
      o_mem_addr  = {1'b0, i_d_addr} + BASE_OFS;
      o_mem_func3 = i_d_func3;
      o_mem_read  = w_d_access & ~i_d_we;
      o_mem_write = w_d_access & i_d_we;
      o_mem_wdata = (w_d_access & i_d_we) ? i_d_wdata : 32'h0;
    end
  end

  assign o_if_gnt = w_if_gnt;
  assign o_d_gnt  = w_d_gnt;

  // Burst counter: counts D grants that IF has had to sit through
  always_comb begin
    w_burst_cnt_d = r_burst_cnt;
    if (!i_if_req || w_if_gnt) begin
      w_burst_cnt_d = '0;
    end else if (w_d_gnt && !w_burst_full) begin
      w_burst_cnt_d = r_burst_cnt + 1'b1;
    end
  end

  // Owner tracking: register / next-state / output
  always_ff @(posedge i_clk) begin
    if (i_rst) r_last_owner <= OwnIdle;
    else       r_last_owner <= w_last_owner_d;
  end

  always_comb begin
    w_last_owner_d = OwnIdle;
    if (w_if_gnt)     w_last_owner_d = OwnFetch;
    else if (w_d_gnt) w_last_owner_d = OwnData;
  end

  always_comb begin
    o_last_owner = r_last_owner;
  end

  // Counter and registered responses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_burst_cnt <= '0;
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= 32'h0;
      o_d_rvalid  <= 1'b0;
      o_d_rdata   <= 32'h0;
      o_d_err     <= 1'b0;
    end else begin
      r_burst_cnt <= w_burst_cnt_d;
      o_if_rvalid <= w_if_gnt;
      o_d_rvalid  <= w_d_resp;
      o_d_err     <= w_d_gnt & w_misaligned;
      if (w_if_gnt) o_if_rdata <= i_mem_rdata;
      if (w_d_resp) o_d_rdata <= w_misaligned ? 32'h0 : i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int unsigned AW   = 8;
  localparam int unsigned BASE = 256;
  localparam int unsigned MAXB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [2:0]    d_func3;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata, d_rdata;
  logic [AW:0]   mem_addr;
  logic          mem_read, mem_write;
  logic [2:0]    mem_func3;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    last_owner;

  int total = 0;
  int bad   = 0;
  // Number of D grants the currently pending IF request has already waited through
  int if_wait = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_BASE(BASE), .MAX_DATA_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
    .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_func3(d_func3), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_d_err(d_err), .o_mem_addr(mem_addr), .o_mem_read(mem_read),
    .o_mem_write(mem_write), .o_mem_func3(mem_func3), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_last_owner(last_owner)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; checks the grant cycle, crosses
  // one edge and checks the response. Returns the model's grants.
  task automatic cycle(output bit gi, output bit gd);
    bit          mis, nifv, ndv, nerr, wr;
    int          size;
    int unsigned eaddr;
    logic [31:0] nifd, ndd;
    logic [1:0]  nown;
    #2;
    gd = d_req && !(if_req && if_wait >= int'(MAXB));
    gi = if_req && !gd;
    chk("if_gnt", if_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    size  = (d_func3 == 3'b001 || d_func3 == 3'b101) ? 2 : (d_func3 == 3'b010) ? 4 : 1;
    mis   = (int'(d_addr) % size) != 0;
    eaddr = int'(d_addr) + BASE;
    wr    = gd && d_we && !mis;
    if (gi) begin
      chk("if_mem_addr", mem_addr, {1'b0, if_addr});
      chk("if_mem_read", mem_read, 1'b1);
      chk("if_mem_write", mem_write, 1'b0);
      chk("if_mem_func3", mem_func3, 3'b010);
    end else if (gd) begin
      chk("d_mem_addr", mem_addr, eaddr);
      chk("d_mem_read", mem_read, !d_we && !mis);
      chk("d_mem_write", mem_write, wr);
      chk("d_mem_wdata", mem_wdata, wr ? d_wdata : 32'h0);
      chk("d_mem_func3", mem_func3, d_func3);
    end else begin
      chk("idle_mem_read", mem_read, 1'b0);
      chk("idle_mem_write", mem_write, 1'b0);
      chk("idle_mem_wdata", mem_wdata, 32'h0);
    end
    nifv = gi && !rst;
    nifd = mem_rdata;
    ndv  = gd && (!d_we || mis) && !rst;
    nerr = gd && mis && !rst;
    ndd  = mis ? 32'h0 : mem_rdata;
    nown = rst ? 2'd0 : gi ? 2'd1 : gd ? 2'd2 : 2'd0;
    if (rst || !if_req || gi) if_wait = 0;
    else if (gd) if_wait++;
    @(posedge clk);
    #1;
    chk("if_rvalid", if_rvalid, nifv);
    if (nifv) chk("if_rdata", if_rdata, nifd);
    chk("d_rvalid", d_rvalid, ndv);
    chk("d_err", d_err, nerr);
    if (ndv) chk("d_rdata", d_rdata, ndd);
    chk("last_owner", last_owner, nown);
  endtask

  initial begin
    bit gi, gd;
    logic [5:0] seq;
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = '0; d_we = 1'b0;
    d_func3 = 3'b010; d_addr = '0; d_wdata = '0; mem_rdata = 32'h1234_5678;
    // T1: reset held two cycles with both requests high
    @(posedge clk);
    #1;
    cycle(gi, gd);
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    cycle(gi, gd);
    // T2: lone fetch
    if_req = 1'b1; if_addr = 8'd8; mem_rdata = 32'hFF00_0213;
    cycle(gi, gd);
    chk("t2_gnt", gi, 1'b1);
    chk("t2_rdata", if_rdata, 32'hFF00_0213);
    if_req = 1'b0;
    cycle(gi, gd);
    // T3: both held high -> D,D,I,D,D,I
    if_req = 1'b1; if_addr = 8'd12; d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010;
    d_addr = 8'd16;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = $urandom;
      cycle(gi, gd);
      seq[i] = gi;
    end
    chk("t3_seq", seq, 6'b100100);
    if_req = 1'b0; d_req = 1'b0;
    cycle(gi, gd);
    // T4: sw to d_addr 4
    d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 8'd4; d_wdata = 32'd5;
    #2;
    chk("t4_mem_addr", mem_addr, 9'd260);
    chk("t4_mem_write", mem_write, 1'b1);
    #(-0);
    cycle(gi, gd);
    // T5: misaligned lw
    d_we = 1'b0; d_func3 = 3'b010; d_addr = 8'd2; mem_rdata = 32'hDEAD_BEEF;
    cycle(gi, gd);
    chk("t5_err", d_err, 1'b1);
    // T6: aligned lh, then the same with reset at the grant edge
    d_func3 = 3'b001; d_addr = 8'd24; mem_rdata = 32'h0000_F157;
    cycle(gi, gd);
    chk("t6_rdata", d_rdata, 32'h0000_F157);
    rst = 1'b1;
    cycle(gi, gd);
    chk("t6_rst_rvalid", d_rvalid, 1'b0);
    rst = 1'b0; d_req = 1'b0;
    cycle(gi, gd);
    // Random traffic with requests held until granted
    for (int n = 0; n < 600; n++) begin
      if (!if_req && $urandom_range(0, 3) != 0) begin
        if_req = 1'b1; if_addr = AW'($urandom);
      end
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1) == 1; d_func3 = 3'($urandom);
        d_addr = AW'($urandom); d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      // Unsupported load sizes read back as zero from the memory
      if (d_req && !d_we && (d_func3 == 3'b011 || d_func3[2:1] == 2'b11)) mem_rdata = 32'h0;
      rst = ($urandom_range(0, 59) == 0);
      cycle(gi, gd);
      if (gi) if_req = 1'b0;
      if (gd) d_req = 1'b0;
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
